// File: rtl/data_pipe_nto1.sv
// ---------------------------------------------------------------------------
// data_pipe_nto1
// Wide-to-narrow serializer. Holds one DSIZE*NSIZE word and emits its valid
// lanes as DSIZE-bit beats, lane 0 (LSBs) first, flagging the final beat with
// rd_last. A new word can be loaded on the same cycle the last beat of the
// previous one is taken, so back-to-back words stream with no bubble.
//
// Ports
//   clock     in   rising-edge clock for all state
//   rst       in   synchronous active-high reset
//   wr_data   in   wide word, lane k = wr_data[k*DSIZE +: DSIZE]
//   wr_lanes  in   valid lane count 1..NSIZE (0 or >NSIZE means NSIZE)
//   wr_vld    in   wide word valid
//   wr_ready  out  block can take a word this cycle (combinational)
//   rd_data   out  current narrow beat (decoded from registers)
//   rd_vld    out  rd_data valid (registered)
//   rd_last   out  current beat is the last valid lane (decoded from registers)
//   rd_ready  in   downstream accepts the beat
// ---------------------------------------------------------------------------
module data_pipe_nto1 #(
    parameter int unsigned DSIZE = 1,
    parameter int unsigned NSIZE = 8,
    localparam int unsigned LW   = $clog2(NSIZE) + 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic [DSIZE*NSIZE-1:0] wr_data,
    input  logic [LW-1:0]          wr_lanes,
    input  logic                   wr_vld,
    output logic                   wr_ready,
    output logic [DSIZE-1:0]       rd_data,
    output logic                   rd_vld,
    output logic                   rd_last,
    input  logic                   rd_ready
);

    localparam int unsigned W  = DSIZE * NSIZE;
    localparam int unsigned IW = $clog2(NSIZE);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state;
    logic [W-1:0]      word_q;
    logic [LW-1:0]     lanes_q;
    logic [IW-1:0]     idx;

    logic [LW-1:0]     lanes_in;
    logic              wr_xfer;
    logic              rd_xfer;

    // Out-of-range lane counts fall back to a full word.
    always_comb begin
        lanes_in = wr_lanes;
        if (wr_lanes == '0 || wr_lanes > LW'(NSIZE)) begin
            lanes_in = LW'(NSIZE);
        end
    end

    // Lane select: explicit mux keeps the index arithmetic width-clean.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < int'(NSIZE); k++) begin
            if (idx == IW'(k)) begin
                rd_data = word_q[k*DSIZE +: DSIZE];
            end
        end
    end

    assign rd_last  = rd_vld && ({1'b0, idx} == (lanes_q - LW'(1)));

    // Ready when empty, or when the last beat leaves this cycle (zero bubble).
    assign wr_ready = !rst && (state == IDLE || (rd_ready && rd_last));

    assign wr_xfer  = wr_vld && wr_ready;
    assign rd_xfer  = rd_vld && rd_ready;

    // Serializer state machine; rd_vld is registered alongside the state.
    always_ff @(posedge clock) begin
        if (rst) begin
            state   <= IDLE;
            rd_vld  <= 1'b0;
            idx     <= '0;
            word_q  <= '0;
            lanes_q <= LW'(NSIZE);
        end else begin
            case (state)
                IDLE: begin
                    if (wr_xfer) begin
                        word_q  <= wr_data;
                        lanes_q <= lanes_in;
                        idx     <= '0;
                        rd_vld  <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (rd_xfer) begin
                        if (!rd_last) begin
                            idx <= idx + IW'(1);
                        end else if (wr_xfer) begin
                            // Reload in place so rd_vld never drops.
                            word_q  <= wr_data;
                            lanes_q <= lanes_in;
                            idx     <= '0;
                        end else begin
                            rd_vld <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    rd_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_pipe_nto1.sv
// ---------------------------------------------------------------------------
// tb_data_pipe_nto1
// Directed bench for data_pipe_nto1 with DSIZE=4, NSIZE=8. Inputs change one
// time unit after the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_data_pipe_nto1;

    localparam int unsigned DSIZE = 4;
    localparam int unsigned NSIZE = 8;
    localparam int unsigned LW    = $clog2(NSIZE) + 1;

    logic                   clock = 1'b0;
    logic                   rst;
    logic [DSIZE*NSIZE-1:0] wr_data;
    logic [LW-1:0]          wr_lanes;
    logic                   wr_vld;
    logic                   wr_ready;
    logic [DSIZE-1:0]       rd_data;
    logic                   rd_vld;
    logic                   rd_last;
    logic                   rd_ready;

    int passes = 0;
    int checks = 0;

    data_pipe_nto1 #(.DSIZE(DSIZE), .NSIZE(NSIZE)) dut (
        .clock    (clock),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_lanes (wr_lanes),
        .wr_vld   (wr_vld),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_vld   (rd_vld),
        .rd_last  (rd_last),
        .rd_ready (rd_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] lane_of(input logic [31:0] d, input int b);
        logic [31:0] s;
        s = d >> (4 * b);
        return s[3:0];
    endfunction

    task automatic beat(input string tag, input logic [3:0] d, input logic last);
        @(negedge clock);
        check({tag, "_vld"},  32'(rd_vld),  32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(d));
        check({tag, "_last"}, 32'(rd_last), 32'(last));
    endtask

    // Write one word with rd_ready held high and check every emitted beat.
    task automatic send_word(input string tag, input logic [31:0] d,
                             input logic [LW-1:0] lanes, input int nbeats);
        wr_data  = d;
        wr_lanes = lanes;
        wr_vld   = 1'b1;
        rd_ready = 1'b1;
        @(negedge clock);
        check({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
        tick();
        wr_vld = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            beat(tag, lane_of(d, b), b == nbeats - 1);
            tick();
        end
        @(negedge clock);
        check({tag, "_idle"}, 32'(rd_vld), 32'd0);
        tick();
    endtask

    initial begin
        int b;
        int cyc;
        rst      = 1'b1;
        wr_data  = '0;
        wr_lanes = '0;
        wr_vld   = 1'b0;
        rd_ready = 1'b0;

        // Reset
        tick();
        @(negedge clock);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_vld",   32'(rd_vld),   32'd0);
        tick();
        rst = 1'b0;
        @(negedge clock);
        check("post_rst_vld",   32'(rd_vld),   32'd0);
        check("post_rst_data",  32'(rd_data),  32'd0);
        check("post_rst_last",  32'(rd_last),  32'd0);
        check("post_rst_ready", 32'(wr_ready), 32'd1);

        // Full word with per-beat wr_ready check
        wr_data  = 32'h7654_3210;
        wr_lanes = 4'd8;
        wr_vld   = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            beat("full", 4'(i), i == 7);
            check("full_wr_ready", 32'(wr_ready), 32'(i == 7));
            tick();
        end
        @(negedge clock);
        check("full_idle", 32'(rd_vld), 32'd0);
        tick();

        // Back-to-back words, wr_vld held high
        wr_data = 32'h7654_3210;
        wr_vld  = 1'b1;
        tick();
        wr_data = 32'hFEDC_BA98;
        for (int i = 0; i < 16; i++) begin
            beat("b2b", 4'(i), i == 7 || i == 15);
            check("b2b_wr_ready", 32'(wr_ready), 32'(i == 7 || i == 15));
            if (i == 15) wr_vld = 1'b0;
            tick();
            if (i == 7) wr_vld = 1'b0;
        end
        @(negedge clock);
        check("b2b_idle", 32'(rd_vld), 32'd0);
        tick();

        // Partial word and lane-count clamp
        send_word("part",    32'hFFFF_FA98, 4'd3,  3);
        send_word("clamp0",  32'h89AB_CDEF, 4'd0,  8);
        send_word("clamp12", 32'h1357_9BDF, 4'd12, 8);
        send_word("one",     32'h0000_0005, 4'd1,  1);

        // Backpressure: rd_ready pattern 1,0,0 repeating
        wr_data  = 32'h3141_5926;
        wr_lanes = 4'd8;
        wr_vld   = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_vld = 1'b0;
        b   = 0;
        cyc = 0;
        while (b < 8 && cyc < 40) begin
            rd_ready = (cyc % 3 == 0);
            beat("bp", lane_of(32'h3141_5926, b), b == 7);
            check("bp_wr_ready", 32'(wr_ready), 32'(rd_ready && b == 7));
            tick();
            if (rd_ready) b++;
            cyc++;
        end
        check("bp_all_beats", 32'(b), 32'd8);
        @(negedge clock);
        check("bp_idle", 32'(rd_vld), 32'd0);
        tick();

        // Reset in the middle of a word
        wr_data  = 32'h7654_3210;
        wr_lanes = 4'd8;
        wr_vld   = 1'b1;
        rd_ready = 1'b1;
        tick();
        wr_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("mid", 4'(i), 1'b0);
            tick();
        end
        rst = 1'b1;
        @(negedge clock);
        check("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clock);
        check("mid_rst_vld",  32'(rd_vld),  32'd0);
        check("mid_rst_data", 32'(rd_data), 32'd0);
        check("mid_rst_last", 32'(rd_last), 32'd0);
        tick();
        send_word("after_rst", 32'hFEDC_BA98, 4'd8, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_pipe_nto1.md
Name: data_pipe_nto1

Overview:
- Wide-to-narrow serializer; the mirror of the 1-to-N combine pipe.
- Sits downstream of the 1-to-N combine pipe, or of any wide FWFT FIFO.
- Accepts one DSIZE*NSIZE word plus a valid-lane count and emits the valid lanes as DSIZE beats, lane 0 (LSBs) first.
- Flags the final beat of each word with rd_last, so the pair round-trips partial words closed by align_last.

Parameters:
- DSIZE, 1, width of one narrow beat (bits).
- NSIZE, 8, lanes per wide word; must be >= 2.
- LW, $clog2(NSIZE)+1, width of wr_lanes; derived, not overridden.

Ports:
- clock  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- wr_data  in  DSIZE*NSIZE  wide word; lane k = wr_data[k*DSIZE +: DSIZE].
- wr_lanes  in  LW  number of valid lanes, 1..NSIZE; 0 or >NSIZE is treated as NSIZE.
- wr_vld  in  1  wide word valid.
- wr_ready  out  1  block can take a word this cycle.
- rd_data  out  DSIZE  current narrow beat.
- rd_vld  out  1  rd_data valid.
- rd_last  out  1  current beat is the last valid lane of its word.
- rd_ready  in  1  downstream accepts the beat.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `rst` is synchronous and active-high; it is sampled only on the clock edge.
- During reset and on the first edge after it: rd_vld=0, rd_last=0, rd_data=0, state=IDLE, idx=0, word register=0, lanes register=NSIZE, wr_ready=0 while rst=1.
- Storage: one held word (word_q), lane limit (lanes_q, 1..NSIZE) and lane index (idx, 0..NSIZE-1).
- Combinational outputs, all decoded from registers only:
  - rd_data = word_q[idx*DSIZE +: DSIZE].
  - rd_last = rd_vld && (idx == lanes_q-1).
- Handshakes:
  - Write transfer = wr_vld && wr_ready.
  - Read transfer = rd_vld && rd_ready.
  - Once rd_vld rises, rd_data and rd_last stay stable until the read transfer.
- wr_ready = !rst && (state==IDLE || (rd_ready && rd_last)).
  - This is the only combinational path from rd_ready to an output.
  - It allows back-to-back words with zero bubble.
- State machine, states IDLE and SEND:
  - IDLE, rd_vld=0: on a write transfer, load word_q and lanes_q (after clamp), set idx=0, go to SEND. rd_vld=1 on the next cycle, so latency is 1 cycle from write to first beat.
  - SEND, rd_vld=1, read transfer with !rd_last: idx <= idx+1, stay in SEND.
  - SEND, read transfer with rd_last and a simultaneous write transfer: reload word_q, lanes_q and idx=0, stay in SEND. rd_vld stays 1 continuously.
  - SEND, read transfer with rd_last and no write: go to IDLE, rd_vld=0.
  - SEND, no read transfer: hold everything.
- Throughput: a word of L lanes occupies exactly L cycles when rd_ready=1 continuously.
  - Full rate is 1 beat per cycle.
  - A word with L=1 gives rd_last on its only beat.
- Lane-count clamp, applied at load: lanes_q = (wr_lanes==0 || wr_lanes>NSIZE) ? NSIZE : wr_lanes.
- Lanes idx >= lanes_q of a word are never emitted.
- wr_vld while wr_ready=0: nothing is captured; the upstream must hold.
- Reset mid-word: the word in flight is discarded and no further beats are emitted. The block returns to IDLE on the reset edge.
- idx never exceeds NSIZE-1 and never wraps past lanes_q-1.

Test Plan:
- Reset, then NSIZE=8, DSIZE=4: write wr_data=32'h7654_3210, wr_lanes=8, rd_ready=1 -> rd_vld rises 1 cycle later; rd_data = 0,1,2,3,4,5,6,7 on consecutive cycles; rd_last only on beat 7; wr_ready low during beats 0-6.
- Back-to-back: words 32'h7654_3210 then 32'hFEDC_BA98, both lanes=8, wr_vld held high, rd_ready=1 -> 16 consecutive beats 0..F, rd_vld never drops, second word accepted in the cycle of beat 7.
- Partial word: wr_data=32'hFFFF_FA98, wr_lanes=3 -> beats 8,9,A with rd_last on A; lanes 3-7 are not emitted; returns to IDLE.
- Clamp: wr_lanes=0, then wr_lanes=12 -> each emits 8 beats; wr_lanes=1 -> 1 beat, rd_last=1 on it.
- Backpressure: toggle rd_ready 1,0,0,1,... during a word -> rd_data and rd_last stable while rd_ready=0; no beat dropped or duplicated; wr_ready=0 while stalled on the last beat.
- Reset after beat 2 of an 8-lane word -> the next cycle has rd_vld=0, rd_data=0; the next written word starts at lane 0 with no leftover beats.
